// File: rtl/rstack_pkg.sv
// Shared constants for the return-address stack: overflow policy codes and
// the default geometry of the 4-bit core's call stack.
package rstack_pkg;

  localparam int OVF_DISCARD = 0;
  localparam int OVF_REJECT  = 1;

  localparam int RS_ADDR_W = 10;
  localparam int RS_DEPTH  = 5;

endpackage

// File: rtl/pc_return_stack.sv
// Parametrised return-address stack beside the program counter: CALL pushes,
// RET/RETSK pops and the PC reloads from top. Shift-array storage, entry 0 is top.
module pc_return_stack
  import rstack_pkg::*;
#(
  parameter int ADDR_W     = RS_ADDR_W,
  parameter int DEPTH      = RS_DEPTH,
  parameter int OVF_POLICY = OVF_DISCARD,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  input  logic                       clr_flags,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          top,
  output logic [ADDR_W-1:0]          rd_data,
  output logic [CNT_W-1:0]           count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entry     [DEPTH];
  logic [ADDR_W-1:0] entry_nxt [DEPTH];
  logic [CNT_W-1:0]  count_nxt;
  logic              ovf_set;
  logic              unf_set;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign top   = entry[0];

  always_comb begin
    entry_nxt = entry;
    count_nxt = count;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (push && pop) begin
      // Replace: only the top changes; on empty it acts as a push that also flags underflow.
      entry_nxt[0] = push_data;
      if (empty) begin
        count_nxt = CNT_W'(1);
        unf_set   = 1'b1;
      end
    end else if (push) begin
      ovf_set = full;
      if (!(full && (OVF_POLICY == OVF_REJECT))) begin
        entry_nxt[0] = push_data;
        for (int i = 1; i < DEPTH; i++) begin
          entry_nxt[i] = entry[i-1];
        end
      end
      if (!full) begin
        count_nxt = count + CNT_W'(1);
      end
    end else if (pop) begin
      // Bottom entry is left in place so repeated pops keep returning it.
      for (int i = 0; i < DEPTH - 1; i++) begin
        entry_nxt[i] = entry[i+1];
      end
      unf_set = empty;
      if (!empty) begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      entry     <= entry_nxt;
      count     <= count_nxt;
      overflow  <= ovf_set | (overflow & ~clr_flags);
      underflow <= unf_set | (underflow & ~clr_flags);
    end
  end

  // Out-of-range debug indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(rd_idx) == i) begin
        rd_data = entry[i];
      end
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack: one instance per overflow policy,
// directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_return_stack;

  logic       clk;
  logic       RESET;
  logic       push;
  logic       pop;
  logic [9:0] push_data;
  logic       clr_flags;
  logic [2:0] rd_idx;

  logic [9:0] top0, rd_data0, top1, rd_data1;
  logic [2:0] count0, count1;
  logic       empty0, full0, ovf0, unf0;
  logic       empty1, full1, ovf1, unf1;

  int checks;
  int errors;

  // Reference model: per policy, five slots with slot 0 the top, plus count and flags.
  logic [9:0] m    [2][5];
  int         mcnt [2];
  bit         movf [2];
  bit         munf [2];

  pc_return_stack #(.ADDR_W(10), .DEPTH(5), .OVF_POLICY(0)) dut0 (
    .clk(clk), .RESET(RESET), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .rd_idx(rd_idx), .top(top0), .rd_data(rd_data0),
    .count(count0), .empty(empty0), .full(full0), .overflow(ovf0), .underflow(unf0)
  );

  pc_return_stack #(.ADDR_W(10), .DEPTH(5), .OVF_POLICY(1)) dut1 (
    .clk(clk), .RESET(RESET), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .rd_idx(rd_idx), .top(top1), .rd_data(rd_data1),
    .count(count1), .empty(empty1), .full(full1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) m[k][i] = '0;
      mcnt[k] = 0;
      movf[k] = 0;
      munf[k] = 0;
    end
  endtask

  task automatic model_step(input bit p, input bit o, input logic [9:0] d, input bit c);
    logic [9:0] q[$];
    logic [9:0] bot;
    for (int k = 0; k < 2; k++) begin
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(m[k][i]);
      bot = q[4];
      if (c) begin
        movf[k] = 0;
        munf[k] = 0;
      end
      if (p && o) begin
        q[0] = d;
        if (mcnt[k] == 0) begin
          mcnt[k] = 1;
          munf[k] = 1;
        end
      end else if (p) begin
        if (mcnt[k] == 5) begin
          movf[k] = 1;
          if (k == 0) begin
            q.push_front(d);
            void'(q.pop_back());
          end
        end else begin
          q.push_front(d);
          void'(q.pop_back());
          mcnt[k] = mcnt[k] + 1;
        end
      end else if (o) begin
        void'(q.pop_front());
        q.push_back(bot);
        if (mcnt[k] == 0) munf[k] = 1;
        else mcnt[k] = mcnt[k] - 1;
      end
      for (int i = 0; i < 5; i++) m[k][i] = q[i];
    end
  endtask

  // One clock of activity; outputs are stable from #1 after the edge.
  task automatic step(input bit p, input bit o, input logic [9:0] d, input bit c);
    push      = p;
    pop       = o;
    push_data = d;
    clr_flags = c;
    @(posedge clk);
    #1;
    model_step(p, o, d, c);
    push      = 1'b0;
    pop       = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    RESET = 1'b0;
    #3;
    RESET = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 10'h155, 1'b0);
    step(1'b1, 1'b1, 10'h2AA, 1'b0);
    #2;
    RESET  = 1'b0;
    rd_idx = 3'd0;
    #1;
    checks++;
    if (top0 !== 10'h0 || rd_data0 !== 10'h0 || count0 !== 3'd0 || empty0 !== 1'b1 ||
        full0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: top=%h rd=%h cnt=%0d e=%b f=%b o=%b u=%b, want 0 0 0 1 0 0 0",
               top0, rd_data0, count0, empty0, full0, ovf0, unf0);
    end
    #2;
    RESET = 1'b1;
    model_reset();
  endtask

  task automatic test_push_basic();
    do_reset();
    step(1'b1, 1'b0, 10'h3C1, 1'b0);
    step(1'b1, 1'b0, 10'h3C2, 1'b0);
    step(1'b1, 1'b0, 10'h3C3, 1'b0);
    rd_idx = 3'd2;
    #1;
    checks++;
    if (top0 !== 10'h3C3 || count0 !== 3'd3 || rd_data0 !== 10'h3C1 || empty0 !== 1'b0 ||
        ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_basic: top=%h cnt=%0d rd2=%h e=%b o=%b u=%b, want 3c3 3 3c1 0 0 0",
               top0, count0, rd_data0, empty0, ovf0, unf0);
    end
    rd_idx = 3'd6;
    #1;
    checks++;
    if (rd_data0 !== 10'h0) begin
      errors++;
      $display("[TB] FAIL rd_out_of_range: rd_data=%h, want 000", rd_data0);
    end
  endtask

  task automatic test_pop_underflow();
    logic [9:0] want;
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 10'h0A0 + 10'(i), 1'b0);
    checks++;
    if (full0 !== 1'b1 || count0 !== 3'd5 || ovf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill: full=%b cnt=%0d ovf=%b, want 1 5 0", full0, count0, ovf0);
    end
    for (int i = 5; i >= 1; i--) begin
      want = 10'h0A0 + 10'(i);
      checks++;
      if (top0 !== want) begin
        errors++;
        $display("[TB] FAIL pop_order_%0d: top=%h, want %h", i, top0, want);
      end
      step(1'b0, 1'b1, 10'h0, 1'b0);
    end
    checks++;
    if (count0 !== 3'd0 || empty0 !== 1'b1 || unf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drained: cnt=%0d empty=%b unf=%b, want 0 1 0", count0, empty0, unf0);
    end
    step(1'b0, 1'b1, 10'h0, 1'b0);
    checks++;
    if (top0 !== 10'h0A1 || unf0 !== 1'b1 || count0 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL sticky_bottom: top=%h unf=%b cnt=%0d, want 0a1 1 0", top0, unf0, count0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
    rd_idx = 3'd4;
    #1;
    checks++;
    if (top0 !== 10'h006 || rd_data0 !== 10'h002 || count0 !== 3'd5 || ovf0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_discard: top=%h rd4=%h cnt=%0d ovf=%b, want 006 002 5 1",
               top0, rd_data0, count0, ovf0);
    end
    checks++;
    if (top1 !== 10'h005 || rd_data1 !== 10'h001 || count1 !== 3'd5 || ovf1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_reject: top=%h rd4=%h cnt=%0d ovf=%b, want 005 001 5 1",
               top1, rd_data1, count1, ovf1);
    end
    // Replace while full must leave overflow alone after a clear.
    step(1'b0, 1'b0, 10'h0, 1'b1);
    step(1'b1, 1'b1, 10'h3FF, 1'b0);
    checks++;
    if (ovf0 !== 1'b0 || top0 !== 10'h3FF || count0 !== 3'd5) begin
      errors++;
      $display("[TB] FAIL replace_full: ovf=%b top=%h cnt=%0d, want 0 3ff 5", ovf0, top0, count0);
    end
  endtask

  task automatic test_replace();
    do_reset();
    step(1'b1, 1'b0, 10'h100, 1'b0);
    step(1'b1, 1'b0, 10'h200, 1'b0);
    step(1'b1, 1'b1, 10'h2FF, 1'b0);
    rd_idx = 3'd1;
    #1;
    checks++;
    if (top0 !== 10'h2FF || rd_data0 !== 10'h100 || count0 !== 3'd2 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL replace: top=%h rd1=%h cnt=%0d o=%b u=%b, want 2ff 100 2 0 0",
               top0, rd_data0, count0, ovf0, unf0);
    end
    do_reset();
    step(1'b1, 1'b1, 10'h123, 1'b0);
    checks++;
    if (top0 !== 10'h123 || count0 !== 3'd1 || unf0 !== 1'b1 || ovf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL replace_empty: top=%h cnt=%0d u=%b o=%b, want 123 1 1 0",
               top0, count0, unf0, ovf0);
    end
  endtask

  task automatic test_clr_flags();
    do_reset();
    step(1'b0, 1'b1, 10'h0, 1'b0);
    checks++;
    if (unf0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unf_set: unf=%b, want 1", unf0);
    end
    step(1'b0, 1'b0, 10'h0, 1'b1);
    checks++;
    if (unf0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_flags: unf=%b, want 0", unf0);
    end
    step(1'b0, 1'b1, 10'h0, 1'b1);
    checks++;
    if (unf0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_beats_clr: unf=%b, want 1", unf0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 10'h050, 1'b0);
    step(1'b1, 1'b0, 10'h060, 1'b0);
    push      = 1'b1;
    push_data = 10'h070;
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (count0 !== 3'd0 || top0 !== 10'h0 || count1 !== 3'd0 || top1 !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: cnt=%0d top=%h, want 0 000", count0, top0);
    end
    push = 1'b0;
    #1;
    RESET = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 10'h071, 1'b0);
    checks++;
    if (count0 !== 3'd1 || top0 !== 10'h071) begin
      errors++;
      $display("[TB] FAIL after_reset_release: cnt=%0d top=%h, want 1 071", count0, top0);
    end
  endtask

  task automatic test_random();
    bit         p, o, c;
    logic [9:0] d;
    logic [9:0] e0, e1;
    int         bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 8);
      d = 10'($urandom);
      step(p, o, d, c);
      rd_idx = 3'($urandom_range(0, 7));
      #1;
      e0 = (rd_idx < 3'd5) ? m[0][rd_idx] : 10'h0;
      e1 = (rd_idx < 3'd5) ? m[1][rd_idx] : 10'h0;
      checks++;
      if (top0 !== m[0][0] || rd_data0 !== e0 || int'(count0) !== mcnt[0] ||
          empty0 !== (mcnt[0] == 0) || full0 !== (mcnt[0] == 5) ||
          ovf0 !== movf[0] || unf0 !== munf[0]) begin
        errors++;
        if (bad < 10)
          $display("[TB] FAIL random_p0 #%0d: top=%h rd=%h cnt=%0d e=%b f=%b o=%b u=%b, want %h %h %0d %b %b %b %b",
                   n, top0, rd_data0, count0, empty0, full0, ovf0, unf0,
                   m[0][0], e0, mcnt[0], (mcnt[0] == 0), (mcnt[0] == 5), movf[0], munf[0]);
        bad++;
      end
      checks++;
      if (top1 !== m[1][0] || rd_data1 !== e1 || int'(count1) !== mcnt[1] ||
          empty1 !== (mcnt[1] == 0) || full1 !== (mcnt[1] == 5) ||
          ovf1 !== movf[1] || unf1 !== munf[1]) begin
        errors++;
        if (bad < 10)
          $display("[TB] FAIL random_p1 #%0d: top=%h rd=%h cnt=%0d e=%b f=%b o=%b u=%b, want %h %h %0d %b %b %b %b",
                   n, top1, rd_data1, count1, empty1, full1, ovf1, unf1,
                   m[1][0], e1, mcnt[1], (mcnt[1] == 0), (mcnt[1] == 5), movf[1], munf[1]);
        bad++;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RESET     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    clr_flags = 1'b0;
    rd_idx    = '0;
    model_reset();
    #12;
    RESET = 1'b1;
    #1;
    test_reset();
    test_push_basic();
    test_pop_underflow();
    test_overflow();
    test_replace();
    test_clr_flags();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Parametrised hardware return-address stack for the 4-bit microcontroller core family; successor to the fixed 5-deep, 10-bit shift-register call stack.
- Sits beside the program counter. The CALL path pushes the current PC; the RET/RETSK path pops and loads the PC from `top`.
- Adds over the fixed stack:
  - configurable depth and width;
  - occupancy count and full/empty status;
  - sticky overflow/underflow error flags;
  - selectable overflow policy;
  - debug read port;
  - proper reset.

Parameters:
- ADDR_W, 10: width of each stored return address.
- DEPTH, 5: number of entries, minimum 2.
- OVF_POLICY, 0: 0 = on a push when full, discard the oldest entry. 1 = on a push when full, reject the push and leave the stack unchanged.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk, input, 1: clock, rising edge.
- RESET, input, 1: reset, asynchronous, active-low.
- push, input, 1: push `push_data` this cycle.
- pop, input, 1: pop the top entry this cycle.
- push_data, input, ADDR_W: address to push.
- clr_flags, input, 1: synchronous clear of the sticky error flags.
- rd_idx, input, $clog2(DEPTH): debug read index; 0 = top.
- top, output, ADDR_W: entry[0], combinational from the register array.
- rd_data, output, ADDR_W: entry[rd_idx], combinational. Returns 0 if rd_idx >= DEPTH.
- count, output, CNT_W: number of valid entries, 0..DEPTH.
- empty, output, 1: count == 0.
- full, output, 1: count == DEPTH.
- overflow, output, 1: sticky; set by a push while full.
- underflow, output, 1: sticky; set by a pop while empty.

Behaviour:
- Reset (RESET low, asynchronous): all entries = 0, count = 0, overflow = 0, underflow = 0. Outputs therefore reset to top = 0, rd_data = 0, empty = 1, full = 0.
- Storage is a shift array: entry[0] is the top, entry[DEPTH-1] is the bottom. All updates happen on the rising edge of clk. Single-cycle latency: `top` reflects an operation on the cycle after its edge.
- Push only:
  - Entries shift down: entry[i+1] <= entry[i], entry[0] <= push_data.
  - If not full: count increments.
  - If full and OVF_POLICY = 0: the old bottom is discarded, count stays DEPTH, overflow <= 1.
  - If full and OVF_POLICY = 1: the array is unchanged, count is unchanged, overflow <= 1.
- Pop only:
  - Entries shift up: entry[i] <= entry[i+1]. entry[DEPTH-1] keeps its value, so the bottom is duplicated. This preserves the legacy sticky-bottom semantics.
  - If count > 0: count decrements.
  - If empty: the shift still occurs, count stays 0, underflow <= 1.
- Push and pop in the same cycle (replace):
  - entry[0] <= push_data; the other entries are unchanged; count is unchanged.
  - If empty: treated as a push, count becomes 1, underflow <= 1.
  - Replace never sets overflow.
- clr_flags: overflow <= 0 and underflow <= 0. If clr_flags coincides with an event that sets a flag, the set wins.
- Neither push nor pop: all state is held.
- Reset asserted mid-operation: state clears immediately. The first edge after release is an ordinary cycle.
- Count arithmetic saturates at 0 and DEPTH and never wraps.

Decomposition:
- Shared package `rstack_pkg`:
  - OVF_DISCARD = 0 and OVF_REJECT = 1 policy constants;
  - the default ADDR_W and DEPTH matching the core.
- No sub-module. A single module with a generate loop over the entries is natural.
- Optional helper `rstack_cnt` (saturating up/down counter) only if it is reused elsewhere.

Test Plan (DEPTH = 5, ADDR_W = 10 unless stated):
- Reset, then push 0x3C1, 0x3C2, 0x3C3 -> top = 0x3C3, count = 3, rd_data(idx 2) = 0x3C1, empty = 0, flags = 0.
- Push A1..A5 (full), then pop 5 times -> pops return A5..A1, count = 0, empty = 1. A 6th pop -> top = A1 (bottom duplicated), underflow = 1, count = 0.
- OVF_POLICY = 0: push 0x001..0x006 -> top = 0x006, rd_data(4) = 0x002, count = 5, overflow = 1.
- OVF_POLICY = 1: same sequence -> top = 0x005, rd_data(4) = 0x001, overflow = 1.
- Push 0x100 then 0x200; assert push and pop together with 0x2FF -> top = 0x2FF, rd_data(1) = 0x100, count = 2, no flags set.
- Set underflow, then assert clr_flags -> underflow = 0 next cycle. clr_flags together with a pop while empty -> underflow stays 1.
- Assert RESET mid-push -> count = 0 and top = 0 immediately, without waiting for a clock edge.
